mac_acc: RTL and testbench



---
 rtl/mac_acc.sv | 125 ++++++++++++
 tb/tb_mac_acc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mac_acc.sv
// mac_acc: accumulates MAC-array column partial sums across input-channel tiles
// and queues saturated per-column results in a small FWFT output FIFO.
module mac_acc #(
    parameter int COLUMN = 6,
    parameter int CW     = 19,
    parameter int OW     = 22,
    parameter int LAT    = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [COLUMN*CW-1:0]   mac_s_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLUMN*OW-1:0]   out_data,
    output logic                   err
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(LAT + DEPTH + 2) + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state, state_n;
    logic [2:0]             sr [LAT];
    logic                   a_valid, a_first, a_last;
    logic                   accept, push, pop, err_set;
    logic [OW-1:0]          acc [COLUMN];
    logic [OW-1:0]          acc_n [COLUMN];
    logic [COLUMN*OW-1:0]   acc_flat;
    logic [COLUMN*OW-1:0]   mem [DEPTH];
    logic [COLUMN*OW-1:0]   hold;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic [IW-1:0]          inflight;

    assign accept = in_valid & in_ready;
    assign {a_valid, a_first, a_last} = sr[LAT-1];

    // sideband {valid, first, last} travels alongside the array pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= accept ? {1'b1, in_first, in_last} : 3'b000;
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
    end

    for (genvar c = 0; c < COLUMN; c++) begin : g_lane
        logic [OW:0] base, sum;
        assign base = (state == ACCUM && !a_first) ? {acc[c][OW-1], acc[c]} : '0;
        assign sum = base + {{(OW+1-CW){mac_s_data[c*CW+CW-1]}}, mac_s_data[c*CW +: CW]};
        assign acc_n[c] = (sum[OW] != sum[OW-1]) ? {sum[OW], {(OW-1){~sum[OW]}}} : sum[OW-1:0];
        assign acc_flat[c*OW +: OW] = acc_n[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < COLUMN; c++) acc[c] <= '0;
        end else if (a_valid) begin
            for (int c = 0; c < COLUMN; c++) acc[c] <= acc_n[c];
        end
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_comb begin
        state_n = a_valid ? (a_last ? IDLE : ACCUM) : state;
    end

    always_comb begin
        push    = a_valid & a_last;
        err_set = a_valid & ((state == IDLE && !a_first) || (state == ACCUM && a_first));
    end

    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : hold;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= acc_flat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // results already committed downstream of the acceptance point
    always_comb begin
        inflight = IW'(accept & in_last);
        for (int i = 0; i < LAT; i++) inflight = inflight + IW'(sr[i][0]);
    end

    always_ff @(posedge clk) begin
        if (rst) in_ready <= 1'b1;
        else in_ready <= (IW'(count) + inflight) < IW'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && count == (AW+1)'(DEPTH) && !pop));
    end
endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: scoreboard bench for mac_acc with a delay-line model of the MAC array.
module tb_mac_acc;
    localparam int COLUMN = 6, CW = 19, OW = 22, LAT = 8, DEPTH = 4;
    localparam int OMAX = 2**(OW-1) - 1;
    localparam int OMIN = -(2**(OW-1));

    logic                 clk = 0, rst = 1;
    logic                 in_valid = 0, in_first = 0, in_last = 0, in_ready;
    logic                 out_valid, out_ready = 1, err;
    logic [COLUMN*CW-1:0] mac_s_data, drv_data = '0;
    logic [COLUMN*OW-1:0] out_data;
    logic [COLUMN*CW-1:0] pipe [LAT];
    logic [COLUMN*OW-1:0] sb [$];
    int                   acc_m [COLUMN];
    bit                   busy_m = 0, err_m = 0;
    int                   checks = 0, errors = 0, accepted = 0, n;

    mac_acc #(.COLUMN(COLUMN), .CW(CW), .OW(OW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_ready(in_ready), .mac_s_data(mac_s_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err(err)
    );

    always #5 clk = ~clk;

    // array model: data for an accepted beat appears LAT edges later
    assign mac_s_data = pipe[LAT-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= (in_valid && in_ready) ? drv_data : '0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic chk(string tag, logic [COLUMN*OW-1:0] got, logic [COLUMN*OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sat(int x);
        return x > OMAX ? OMAX : (x < OMIN ? OMIN : x);
    endfunction

    function automatic logic [COLUMN*OW-1:0] rep(int v);
        logic [COLUMN*OW-1:0] r;
        for (int c = 0; c < COLUMN; c++) r[c*OW +: OW] = OW'(v);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_pop", out_valid, 0);
            else chk("result", out_data, sb.pop_front());
        end
    end

    task automatic beat(bit f, bit l, int v, int spread = 0);
        int k = 0;
        bit start;
        logic [COLUMN*OW-1:0] e;
        in_valid = 1; in_first = f; in_last = l;
        for (int c = 0; c < COLUMN; c++) drv_data[c*CW +: CW] = CW'(v + spread*c);
        while (!in_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        else begin
            start = f || !busy_m;
            if ((!busy_m && !f) || (busy_m && f)) err_m = 1;
            for (int c = 0; c < COLUMN; c++) begin
                acc_m[c] = sat((start ? 0 : acc_m[c]) + v + spread*c);
                e[c*OW +: OW] = OW'(acc_m[c]);
            end
            if (l) sb.push_back(e);
            busy_m = !l;
            @(posedge clk); #1;
            accepted++;
        end
        in_valid = 0; in_first = 0; in_last = 0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk); k++;
        end
        chk("drain", sb.size(), 0);
        chk("err", err, err_m);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1; rst = 0;

        beat(1, 1, 5);
        wait_out(n);
        chk("lat_single", n, LAT);
        drain();

        beat(1, 0, 100); beat(0, 0, -30); beat(0, 1, 7);
        wait_out(n);
        chk("lat_three", n, LAT);
        drain();

        for (int i = 0; i < 9; i++) beat(i == 0, i == 8, 2**18 - 1);
        for (int i = 0; i < 9; i++) beat(i == 0, i == 8, -(2**18));
        drain();

        beat(1, 0, 1000, -300); beat(0, 1, -7, 11);
        drain();

        out_ready = 0; accepted = 0;
        fork
            for (int i = 1; i <= 6; i++) beat(1, 1, i);
            begin
                repeat (20) @(posedge clk);
                #2;
                chk("bp_accepted", accepted, 4);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_head", out_data, rep(1));
                out_ready = 1;
            end
        join
        drain();
        chk("bp_total", accepted, 6);

        beat(0, 1, 3);
        drain();
        beat(1, 0, 10); beat(1, 1, 20);
        drain();

        beat(1, 0, 4); beat(0, 0, 4);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        sb.delete(); busy_m = 0; err_m = 0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        beat(1, 1, 9);
        wait_out(n);
        chk("lat_after_rst", n, LAT);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
